ps2_packet_rx: RTL and testbench
================================

PS2_PACKET_RX -- requirements
Module: ps2_packet_rx

Interface
REQ-001 Parameter WORDS, default 3: bytes per packet; legal range 1..4.
REQ-002 Parameter TIMEOUT_CYCLES, default 100000: i_clk cycles without a PS/2 falling edge before a partial packet is abandoned; legal range 16..2^20.
REQ-003 i_clk  input  1: single system clock; all state on its rising edge.
REQ-004 i_reset  input  1: synchronous, active-high reset.
REQ-005 i_PS2Clk  input  1: asynchronous PS/2 clock line.
REQ-006 i_PS2Data  input  1: asynchronous PS/2 data line.
REQ-007 o_packet  output  WORDS*8: last complete valid packet; first-received byte in bits [WORDS*8-1 -: 8], last byte in [7:0].
REQ-008 o_valid  output  1: one-cycle pulse when o_packet is updated.
REQ-009 o_frame_err  output  1: one-cycle pulse on a frame that fails start, parity or stop checks.
REQ-010 o_timeout  output  1: one-cycle pulse when a partial frame or packet is abandoned by the watchdog.
REQ-011 o_busy  output  1: high while the bit counter or the byte index is non-zero.

Function
REQ-012 i_PS2Clk and i_PS2Data SHALL each pass through a two-flop synchroniser before use.
REQ-013 A falling edge SHALL be detected when the previous synchronised clock is 1 and the current one is 0; synchronised data SHALL be sampled in that cycle.
REQ-014 A frame SHALL be 11 bits: start (0), 8 data bits LSB first, odd parity, stop (1).
REQ-015 A 4-bit bit counter SHALL count 0..10 and return to 0 after the 11th sampled bit.
REQ-016 On the 11th bit the frame SHALL be valid only if start==0, the 9 data+parity bits hold an odd number of ones, and stop==1.
REQ-017 A valid frame SHALL store its byte at the current byte index and increment the index.
REQ-018 A valid frame at byte index WORDS-1 SHALL load o_packet with all WORDS bytes, pulse o_valid, and clear the byte index.
REQ-019 o_valid SHALL assert in the clock cycle after the cycle in which the stop-bit falling edge is detected.
REQ-020 An invalid frame SHALL pulse o_frame_err with the same latency as o_valid, clear the byte index, discard the partial packet, and leave o_packet unchanged.
REQ-021 o_packet SHALL hold its value between updates.
REQ-022 o_valid, o_frame_err and o_timeout SHALL be mutually exclusive in any cycle.
REQ-023 A falling edge in the cycle the watchdog would expire SHALL take priority; the edge is sampled and no timeout occurs.
REQ-024 Only the completing stop bit of a valid frame SHALL update o_packet; a partial packet SHALL never be exposed.

Reset
REQ-025 On i_reset: o_packet=0, o_valid=0, o_frame_err=0, o_timeout=0, o_busy=0, bit counter=0, byte index=0, watchdog=0, synchroniser flops=1.
REQ-026 Reset asserted mid-frame or mid-packet SHALL discard all partial data and produce no pulse on any output.

Configuration
REQ-027 With macro PS2_RX_TIMEOUT_EN defined, a watchdog SHALL count cycles while o_busy=1, clear on every falling edge, and on reaching TIMEOUT_CYCLES pulse o_timeout and clear the bit counter, byte index and partial data.
REQ-028 Without PS2_RX_TIMEOUT_EN, no watchdog logic SHALL exist, o_timeout SHALL be constant 0, and a partial frame SHALL wait indefinitely.

Verification
REQ-029 WORDS=3: send bytes 0x08 (p=0), 0x01 (p=0), 0xFF (p=1) -> o_packet=24'h0801FF, o_valid high exactly 1 cycle, o_busy=0 afterward.
REQ-030 WORDS=3: send 0x08, then 0x01 with parity=1 -> o_frame_err 1 pulse, no o_valid; then 0x09, 0x02, 0x03 -> o_packet=24'h090203.
REQ-031 Send one frame with stop bit=0 -> o_frame_err pulse, byte index back to 0, o_packet unchanged.
REQ-032 PS2_RX_TIMEOUT_EN, TIMEOUT_CYCLES=64: send 5 bits, idle 70 cycles -> o_timeout 1 pulse at cycle 64, o_busy=0; then packet 0x08,0x00,0x00 -> o_packet=24'h080000.
REQ-033 Assert i_reset for 1 cycle after 2 bytes of a 3-byte packet -> all outputs 0, no pulses; a following full packet 0x01,0x02,0x03 -> o_packet=24'h010203.
REQ-034 WORDS=4: send 0x08, 0x10, 0x20, 0x0F -> o_packet=32'h0810200F, single o_valid pulse.

Source files
------------

// File: rtl/ps2_packet_rx.sv
// PS/2 receiver that checks 11-bit frames and assembles WORDS bytes into one packet.
// Defining PS2_RX_TIMEOUT_EN adds a watchdog that abandons stalled partial packets.
module ps2_packet_rx #(
    parameter int WORDS          = 3,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_PS2Clk,
    input  logic               i_PS2Data,
    output logic [WORDS*8-1:0] o_packet,
    output logic               o_valid,
    output logic               o_frame_err,
    output logic               o_timeout,
    output logic               o_busy
);

    localparam int         PW       = WORDS * 8;
    localparam logic [1:0] LAST_IDX = 2'(WORDS - 1);

    logic          clk_meta_q, clk_meta_d;
    logic          clk_sync_q, clk_sync_d;
    logic          clk_prev_q, clk_prev_d;
    logic          dat_meta_q, dat_meta_d;
    logic          dat_sync_q, dat_sync_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [9:0]    shift_q, shift_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [PW-1:0] partial_q, partial_d;
    logic [PW-1:0] packet_q, packet_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;

    logic          fall_edge;
    logic          frame_ok;
    logic          busy;
    logic [PW-1:0] byte_placed;
    int            shamt;

`ifdef PS2_RX_TIMEOUT_EN
    localparam logic [20:0] WD_LOAD = 21'(TIMEOUT_CYCLES);
    logic [20:0] wdog_q, wdog_d;
    logic        timeout_q, timeout_d;
`endif

    assign fall_edge = clk_prev_q & ~clk_sync_q;
    assign busy      = (bit_cnt_q != 4'd0) || (byte_idx_q != 2'd0);

    // shift_q holds start in [0], data LSB-first in [8:1], parity in [9]; stop is the live sample
    assign frame_ok  = (shift_q[0] == 1'b0) && (^shift_q[9:1]) && dat_sync_q;

    always_comb begin
        clk_meta_d  = i_PS2Clk;
        clk_sync_d  = clk_meta_q;
        clk_prev_d  = clk_sync_q;
        dat_meta_d  = i_PS2Data;
        dat_sync_d  = dat_meta_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        byte_idx_d  = byte_idx_q;
        partial_d   = partial_q;
        packet_d    = packet_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        shamt       = 8 * (WORDS - 1 - int'(byte_idx_q));
        byte_placed = PW'(shift_q[8:1]) << shamt;

        if (fall_edge) begin
            if (bit_cnt_q == 4'd10) begin
                bit_cnt_d = 4'd0;
                shift_d   = 10'd0;
                if (frame_ok) begin
                    if (byte_idx_q == LAST_IDX) begin
                        packet_d   = partial_q | byte_placed;
                        valid_d    = 1'b1;
                        byte_idx_d = 2'd0;
                        partial_d  = '0;
                    end else begin
                        partial_d  = partial_q | byte_placed;
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end else begin
                    err_d      = 1'b1;
                    byte_idx_d = 2'd0;
                    partial_d  = '0;
                end
            end else begin
                shift_d   = {dat_sync_q, shift_q[9:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end
    end

`ifdef PS2_RX_TIMEOUT_EN
    // Down-counter reloaded on every edge; expiry at terminal count 1 while busy
    always_comb begin
        wdog_d    = wdog_q;
        timeout_d = 1'b0;
        if (fall_edge) begin
            wdog_d = WD_LOAD;
        end else if (!busy) begin
            wdog_d = 21'd0;
        end else if (wdog_q <= 21'd1) begin
            wdog_d    = 21'd0;
            timeout_d = 1'b1;
        end else begin
            wdog_d = wdog_q - 21'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wdog_q    <= 21'd0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 10'd0;
            byte_idx_q <= 2'd0;
            partial_q  <= '0;
            packet_q   <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            clk_meta_q <= clk_meta_d;
            clk_sync_q <= clk_sync_d;
            clk_prev_q <= clk_prev_d;
            dat_meta_q <= dat_meta_d;
            dat_sync_q <= dat_sync_d;
`ifdef PS2_RX_TIMEOUT_EN
            if (timeout_d) begin
                bit_cnt_q  <= 4'd0;
                shift_q    <= 10'd0;
                byte_idx_q <= 2'd0;
                partial_q  <= '0;
            end else begin
                bit_cnt_q  <= bit_cnt_d;
                shift_q    <= shift_d;
                byte_idx_q <= byte_idx_d;
                partial_q  <= partial_d;
            end
`else
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            byte_idx_q <= byte_idx_d;
            partial_q  <= partial_d;
`endif
            packet_q   <= packet_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign o_packet    = packet_q;
    assign o_valid     = valid_q;
    assign o_frame_err = err_q;
    assign o_busy      = busy;

endmodule

// File: tb/tb_ps2_packet_rx.sv
// Bench for ps2_packet_rx: directed vector table, corner sequences, randomized frames vs a byte-queue model.
module tb_ps2_packet_rx;
    localparam int TO = 64;
    localparam int H  = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ps2c_a = 1'b1, ps2d_a = 1'b1, ps2c_b = 1'b1, ps2d_b = 1'b1;
    logic [23:0] pkt_a;
    logic [31:0] pkt_b;
    logic v_a, e_a, t_a, b_a, v_b, e_b, t_b, b_b;

    ps2_packet_rx #(.WORDS(3), .TIMEOUT_CYCLES(TO)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_PS2Clk(ps2c_a), .i_PS2Data(ps2d_a),
        .o_packet(pkt_a), .o_valid(v_a), .o_frame_err(e_a), .o_timeout(t_a), .o_busy(b_a));

    ps2_packet_rx #(.WORDS(4), .TIMEOUT_CYCLES(TO)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_PS2Clk(ps2c_b), .i_PS2Data(ps2d_b),
        .o_packet(pkt_b), .o_valid(v_b), .o_frame_err(e_b), .o_timeout(t_b), .o_busy(b_b));

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0;
    int nv_a = 0, ne_a = 0, nt_a = 0, nv_b = 0, ne_b = 0, nt_b = 0, n_excl = 0;
    int last_to_cyc = 0, last_fall_cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (v_a) nv_a++;
        if (e_a) ne_a++;
        if (t_a) begin nt_a++; last_to_cyc = cyc; end
        if (v_b) nv_b++;
        if (e_b) ne_b++;
        if (t_b) nt_b++;
        if ((32'(v_a) + 32'(e_a) + 32'(t_a)) > 1) n_excl++;
        if ((32'(v_b) + 32'(e_b) + 32'(t_b)) > 1) n_excl++;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1, "time limit");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input bit sel, input bit b);
        if (sel) ps2d_b = b; else ps2d_a = b;
        wait_cyc(H);
        if (sel) ps2c_b = 1'b0;
        else begin
            ps2c_a = 1'b0;
            last_fall_cyc = cyc;
        end
        wait_cyc(H);
        if (sel) ps2c_b = 1'b1; else ps2c_a = 1'b1;
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input bit start_v,
                              input bit pflip, input bit stop_v);
        send_bit(sel, start_v);
        for (int i = 0; i < 8; i++) send_bit(sel, d[i]);
        send_bit(sel, (~^d) ^ pflip);
        send_bit(sel, stop_v);
        wait_cyc(4);
    endtask

    task automatic frame_a(input string name, input logic [7:0] d, input bit start_v, input bit pflip,
                           input bit stop_v, input int ev, input int ee, input logic [23:0] epkt,
                           input bit ebusy);
        int v0, e0;
        v0 = nv_a;
        e0 = ne_a;
        send_frame(1'b0, d, start_v, pflip, stop_v);
        chk({name, "_valid_cnt"}, 32'(nv_a - v0), 32'(ev));
        chk({name, "_err_cnt"}, 32'(ne_a - e0), 32'(ee));
        chk({name, "_packet"}, 32'(pkt_a), 32'(epkt));
        chk({name, "_busy"}, 32'(b_a), 32'(ebusy));
    endtask

    typedef struct {
        logic [7:0]  d;
        bit          start_v;
        bit          pflip;
        bit          stop_v;
        int          ev;
        int          ee;
        logic [23:0] pkt;
        bit          busy;
    } vec_t;

    vec_t vecs[12];
    logic [7:0]  mq[$];
    logic [23:0] exp_pkt;

    initial begin
        vecs[0]  = '{8'h08, 0, 0, 1, 0, 0, 24'h000000, 1};
        vecs[1]  = '{8'h01, 0, 0, 1, 0, 0, 24'h000000, 1};
        vecs[2]  = '{8'hFF, 0, 0, 1, 1, 0, 24'h0801FF, 0};
        vecs[3]  = '{8'h08, 0, 0, 1, 0, 0, 24'h0801FF, 1};
        vecs[4]  = '{8'h01, 0, 1, 1, 0, 1, 24'h0801FF, 0};
        vecs[5]  = '{8'h09, 0, 0, 1, 0, 0, 24'h0801FF, 1};
        vecs[6]  = '{8'h02, 0, 0, 1, 0, 0, 24'h0801FF, 1};
        vecs[7]  = '{8'h03, 0, 0, 1, 1, 0, 24'h090203, 0};
        vecs[8]  = '{8'h55, 0, 0, 0, 0, 1, 24'h090203, 0};
        vecs[9]  = '{8'hA5, 1, 0, 1, 0, 1, 24'h090203, 0};
        vecs[10] = '{8'h3C, 0, 0, 1, 0, 0, 24'h090203, 1};
        vecs[11] = '{8'hC3, 0, 0, 0, 0, 1, 24'h090203, 0};

        wait_cyc(4);
        rst = 1'b0;
        wait_cyc(2);
        chk("reset_packet", 32'(pkt_a), 32'h0);
        chk("reset_busy", 32'(b_a), 32'h0);
        chk("reset_pulses", 32'({v_a, e_a, t_a}), 32'h0);
        chk("reset_packet_w4", pkt_b, 32'h0);

        for (int i = 0; i < 12; i++)
            frame_a($sformatf("vec%0d", i), vecs[i].d, vecs[i].start_v, vecs[i].pflip,
                    vecs[i].stop_v, vecs[i].ev, vecs[i].ee, vecs[i].pkt, vecs[i].busy);

        // randomized frames against a byte-queue packet model
        exp_pkt = 24'h090203;
        for (int i = 0; i < 40; i++) begin
            logic [7:0] d;
            int r, ev, ee;
            bit sv, pf, pv;
            d  = 8'($urandom_range(0, 255));
            r  = $urandom_range(0, 15);
            sv = (r == 0);
            pf = (r == 1);
            pv = (r != 2);
            ev = 0;
            ee = 0;
            if (!sv && !pf && pv) begin
                mq.push_back(d);
                if (mq.size() == 3) begin
                    exp_pkt = {mq[0], mq[1], mq[2]};
                    mq.delete();
                    ev = 1;
                end
            end else begin
                mq.delete();
                ee = 1;
            end
            frame_a($sformatf("rnd%0d", i), d, sv, pf, pv, ev, ee, exp_pkt, mq.size() != 0);
        end
        while (mq.size() != 0) begin
            mq.push_back(8'h00);
            if (mq.size() == 3) begin
                exp_pkt = {mq[0], mq[1], mq[2]};
                mq.delete();
                frame_a("flush", 8'h00, 0, 0, 1, 1, 0, exp_pkt, 0);
            end else begin
                frame_a("flush", 8'h00, 0, 0, 1, 0, 0, exp_pkt, 1);
            end
        end

        // reset in the middle of a packet
        frame_a("mid_b0", 8'h11, 0, 0, 1, 0, 0, exp_pkt, 1);
        frame_a("mid_b1", 8'h22, 0, 0, 1, 0, 0, exp_pkt, 1);
        begin
            int p0;
            p0 = nv_a + ne_a + nt_a;
            rst = 1'b1;
            wait_cyc(1);
            rst = 1'b0;
            wait_cyc(3);
            chk("midrst_packet", 32'(pkt_a), 32'h0);
            chk("midrst_busy", 32'(b_a), 32'h0);
            chk("midrst_pulses", 32'(nv_a + ne_a + nt_a - p0), 32'h0);
        end
        frame_a("post_b0", 8'h01, 0, 0, 1, 0, 0, 24'h0, 1);
        frame_a("post_b1", 8'h02, 0, 0, 1, 0, 0, 24'h0, 1);
        frame_a("post_b2", 8'h03, 0, 0, 1, 1, 0, 24'h010203, 0);

        // stalled partial frame
        begin
            int t0;
            t0 = nt_a;
            send_bit(1'b0, 1'b0);
            send_bit(1'b0, 1'b1);
            send_bit(1'b0, 1'b0);
            send_bit(1'b0, 1'b1);
            send_bit(1'b0, 1'b0);
`ifdef PS2_RX_TIMEOUT_EN
            wait_cyc(70);
            chk("to_count", 32'(nt_a - t0), 32'h1);
            chk("to_latency_in_range",
                32'((last_to_cyc - last_fall_cyc >= TO) && (last_to_cyc - last_fall_cyc <= TO + 6)), 32'h1);
            chk("to_busy", 32'(b_a), 32'h0);
            chk("to_packet", 32'(pkt_a), 32'h010203);
`else
            wait_cyc(200);
            chk("noto_count", 32'(nt_a - t0), 32'h0);
            chk("noto_busy", 32'(b_a), 32'h1);
            chk("noto_packet", 32'(pkt_a), 32'h010203);
            rst = 1'b1;
            wait_cyc(1);
            rst = 1'b0;
            wait_cyc(2);
            chk("noto_rst_busy", 32'(b_a), 32'h0);
`endif
        end
`ifdef PS2_RX_TIMEOUT_EN
        frame_a("to_p0", 8'h08, 0, 0, 1, 0, 0, 24'h010203, 1);
        frame_a("to_p1", 8'h00, 0, 0, 1, 0, 0, 24'h010203, 1);
        frame_a("to_p2", 8'h00, 0, 0, 1, 1, 0, 24'h080000, 0);
`else
        frame_a("to_p0", 8'h08, 0, 0, 1, 0, 0, 24'h0, 1);
        frame_a("to_p1", 8'h00, 0, 0, 1, 0, 0, 24'h0, 1);
        frame_a("to_p2", 8'h00, 0, 0, 1, 1, 0, 24'h080000, 0);
`endif

        // four-byte packet on the WORDS=4 instance
        begin
            int v0;
            logic [7:0] w4[4];
            w4[0] = 8'h08; w4[1] = 8'h10; w4[2] = 8'h20; w4[3] = 8'h0F;
            v0 = nv_b;
            for (int i = 0; i < 3; i++) begin
                send_frame(1'b1, w4[i], 0, 0, 1);
                chk($sformatf("w4_b%0d_busy", i), 32'(b_b), 32'h1);
            end
            chk("w4_no_early_valid", 32'(nv_b - v0), 32'h0);
            send_frame(1'b1, w4[3], 0, 0, 1);
            chk("w4_valid_cnt", 32'(nv_b - v0), 32'h1);
            chk("w4_packet", pkt_b, 32'h0810200F);
            chk("w4_busy", 32'(b_b), 32'h0);
            chk("w4_err_cnt", 32'(ne_b), 32'h0);
        end

        chk("pulse_exclusive", 32'(n_excl), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
